// File: rtl/audio_fx_pkg.sv
// Shared constants and types for the audio effects datapath.
package audio_fx_pkg;

  localparam int unsigned SAMPLE_W_DEFAULT = 16;
  localparam int unsigned GAIN_UNITY       = 512;
  localparam int unsigned GAIN_SHIFT       = 9;
  localparam int unsigned LFO_MAX          = 512;

  typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;
  typedef logic [9:0]                         gain_t;

endpackage

// File: rtl/tremolo_gain_slew.sv
// Slew-limited gain register: moves gain_cur toward target by at most SLEW_STEP
// per enabled cycle and exposes the updated value combinationally.
module tremolo_gain_slew
  import audio_fx_pkg::*;
#(
  parameter int unsigned SLEW_STEP = 8
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  en,
  input  gain_t target,
  output gain_t gain_upd
);

  localparam logic signed [11:0] STEP_S = 12'(SLEW_STEP);
  localparam gain_t              STEP_G = 10'(SLEW_STEP);

  gain_t              gain_cur_q, gain_cur_d;
  logic signed [11:0] diff;

  always_comb begin
    diff = $signed({2'b00, target}) - $signed({2'b00, gain_cur_q});
    if (SLEW_STEP == 0)
      gain_upd = target;
    else if (diff > STEP_S)
      gain_upd = gain_cur_q + STEP_G;
    else if (diff < -STEP_S)
      gain_upd = gain_cur_q - STEP_G;
    else
      gain_upd = target;
    gain_cur_d = en ? gain_upd : gain_cur_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) gain_cur_q <= 10'(GAIN_UNITY);
    else     gain_cur_q <= gain_cur_d;
  end

endmodule

// File: rtl/tremolo_mod.sv
// Tremolo stage: 4-edge pipeline scaling audio by a depth/LFO-derived gain
// that is slew-limited; bypass forces unity gain while the gain keeps tracking.
module tremolo_mod
  import audio_fx_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int unsigned SLEW_STEP = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       in_valid,
  input  logic [31:0]                lfo,
  input  logic [7:0]                 depth,
  input  logic                       bypass,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_valid
);

  localparam int unsigned PW = SAMPLE_W + 11;

  // S0: accepted inputs
  logic                       s0_valid_q, s0_valid_d;
  logic signed [SAMPLE_W-1:0] s0_sample_q, s0_sample_d;
  logic [7:0]                 s0_depth_q, s0_depth_d;
  logic                       s0_bypass_q, s0_bypass_d;
  gain_t                      s0_lfo_q, s0_lfo_d;
  // S1: target gain
  logic                       s1_valid_q, s1_valid_d;
  logic signed [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;
  logic                       s1_bypass_q, s1_bypass_d;
  gain_t                      s1_target_q, s1_target_d;
  // S2: product
  logic                       s2_valid_q, s2_valid_d;
  logic signed [PW-1:0]       s2_prod_q, s2_prod_d;
  // S3: output
  logic                       out_valid_q, out_valid_d;
  logic signed [SAMPLE_W-1:0] sample_out_q, sample_out_d;

  logic [16:0] atten_prod;
  logic [8:0]  atten;
  gain_t       gain_upd;
  gain_t       g_eff;

  tremolo_gain_slew #(.SLEW_STEP(SLEW_STEP)) u_slew (
    .CLK      (CLK),
    .RST      (RST),
    .en       (s1_valid_q),
    .target   (s1_target_q),
    .gain_upd (gain_upd)
  );

  always_comb begin
    s0_valid_d  = in_valid;
    s0_sample_d = in_valid ? sample_in : s0_sample_q;
    s0_depth_d  = in_valid ? depth     : s0_depth_q;
    s0_bypass_d = in_valid ? bypass    : s0_bypass_q;
    s0_lfo_d    = s0_lfo_q;
    if (in_valid)
      s0_lfo_d = (lfo > 32'(LFO_MAX)) ? 10'(LFO_MAX) : lfo[9:0];

    atten_prod  = 17'(s0_depth_q) * 17'(10'(LFO_MAX) - s0_lfo_q);
    atten       = 9'(atten_prod >> 8);
    s1_valid_d  = s0_valid_q;
    s1_sample_d = s0_valid_q ? s0_sample_q : s1_sample_q;
    s1_bypass_d = s0_valid_q ? s0_bypass_q : s1_bypass_q;
    s1_target_d = s0_valid_q ? (10'(GAIN_UNITY) - {1'b0, atten}) : s1_target_q;

    g_eff      = s1_bypass_q ? 10'(GAIN_UNITY) : gain_upd;
    s2_valid_d = s1_valid_q;
    s2_prod_d  = s1_valid_q ? PW'(s1_sample_q) * PW'($signed({1'b0, g_eff})) : s2_prod_q;

    out_valid_d  = s2_valid_q;
    sample_out_d = s2_valid_q ? SAMPLE_W'(s2_prod_q >>> GAIN_SHIFT) : sample_out_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_valid_q   <= 1'b0;
      s0_sample_q  <= '0;
      s0_depth_q   <= '0;
      s0_bypass_q  <= 1'b0;
      s0_lfo_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_sample_q  <= '0;
      s1_bypass_q  <= 1'b0;
      s1_target_q  <= 10'(GAIN_UNITY);
      s2_valid_q   <= 1'b0;
      s2_prod_q    <= '0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
    end else begin
      s0_valid_q   <= s0_valid_d;
      s0_sample_q  <= s0_sample_d;
      s0_depth_q   <= s0_depth_d;
      s0_bypass_q  <= s0_bypass_d;
      s0_lfo_q     <= s0_lfo_d;
      s1_valid_q   <= s1_valid_d;
      s1_sample_q  <= s1_sample_d;
      s1_bypass_q  <= s1_bypass_d;
      s1_target_q  <= s1_target_d;
      s2_valid_q   <= s2_valid_d;
      s2_prod_q    <= s2_prod_d;
      out_valid_q  <= out_valid_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// Directed bench for tremolo_mod: hand-computed vectors plus a behavioural gain model.
module tb_tremolo_mod;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [15:0] sample_in;
  logic               in_valid;
  logic [31:0]        lfo;
  logic [7:0]         depth;
  logic               bypass;
  logic signed [15:0] sample_out;
  logic               out_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int gain_m = 512;

  int outq[$], outc[$], expq[$], expc[$], got[$], sin[$];

  tremolo_mod #(.SAMPLE_W(16), .SLEW_STEP(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .sample_in  (sample_in),
    .in_valid   (in_valid),
    .lfo        (lfo),
    .depth      (depth),
    .bypass     (bypass),
    .sample_out (sample_out),
    .out_valid  (out_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #1;
    if (out_valid) begin
      outq.push_back(int'(sample_out));
      outc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int s, input logic [31:0] l, input int d, input bit byp);
    int lc, at, tg, diff, g;
    lc   = (l > 32'd512) ? 512 : int'(l);
    at   = (d * (512 - lc)) >>> 8;
    tg   = 512 - at;
    diff = tg - gain_m;
    if (diff > 8)       gain_m = gain_m + 8;
    else if (diff < -8) gain_m = gain_m - 8;
    else                gain_m = tg;
    g = byp ? 512 : gain_m;
    return (s * g) >>> 9;
  endfunction

  task automatic send(input int s, input logic [31:0] l, input int d, input bit byp);
    sample_in = 16'(s);
    lfo       = l;
    depth     = 8'(d);
    bypass    = byp;
    in_valid  = 1'b1;
    @(posedge CLK); #1;
    expq.push_back(model(s, l, d, byp));
    expc.push_back(cyc + 3);
    sin.push_back(s);
    in_valid = 1'b0;
  endtask

  task automatic clear_q();
    outq.delete(); outc.delete(); expq.delete(); expc.delete(); sin.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    gain_m = 512;
    clear_q();
  endtask

  task automatic drain(input string tag);
    int o, oc, e, ec;
    repeat (6) @(posedge CLK);
    #2;
    chk({tag, "_count"}, outq.size(), expq.size());
    got.delete();
    while (outq.size() > 0 && expq.size() > 0) begin
      o = outq.pop_front(); oc = outc.pop_front();
      e = expq.pop_front(); ec = expc.pop_front();
      chk({tag, "_data"}, o, e);
      chk({tag, "_lat"}, oc, ec);
      got.push_back(o);
    end
    outq.delete(); outc.delete(); expq.delete(); expc.delete();
  endtask

  initial begin
    int s;
    logic [31:0] l;
    RST = 1'b1; in_valid = 1'b0; sample_in = '0; lfo = '0; depth = '0; bypass = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out", int'(sample_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    RST = 1'b0;

    // full depth at LFO max: unity gain, fixed 3-edge latency
    do_reset();
    send(1000, 32'd512, 255, 1'b0);
    drain("t1");
    chk("t1_n", got.size(), 1);
    if (got.size() == 1) chk("t1_val", got[0], 1000);
    chk("t1_hold", int'(sample_out), 1000);
    chk("t1_strobe", int'(out_valid), 0);

    do_reset();
    send(-1234, 32'd0, 0, 1'b0);
    drain("t2");
    if (got.size() == 1) chk("t2_val", got[0], -1234);

    // slew from 512 down to target 2 in steps of 8
    do_reset();
    for (int i = 0; i < 64; i++) send(1000, 32'd0, 255, 1'b0);
    send(-1000, 32'd0, 255, 1'b0);
    drain("t3");
    chk("t3_n", got.size(), 65);
    if (got.size() == 65) begin
      chk("t3_first", got[0], 984);
      chk("t3_63rd", got[62], 15);
      chk("t3_64th", got[63], 3);
      chk("t3_neg_floor", got[64], -4);
    end

    do_reset();
    send(1000, 32'hFFFF_FFFF, 255, 1'b0);
    send(-32768, 32'd512, 200, 1'b0);
    drain("t4");
    if (got.size() == 2) begin
      chk("t4_clamp", got[0], 1000);
      chk("t4_minval", got[1], -32768);
    end

    // full-rate random stream with a bypass window in the middle
    do_reset();
    for (int i = 0; i < 48; i++) begin
      s = int'($urandom_range(0, 65535)) - 32768;
      l = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 520));
      send(s, l, int'($urandom_range(0, 255)), (i >= 16 && i < 28));
    end
    begin
      int sin_c[$];
      sin_c = sin;
      drain("t5");
      if (got.size() == 48)
        for (int i = 16; i < 28; i += 3) chk("t5_bypass_eq", got[i], sin_c[i]);
    end

    // reset with three samples in flight
    do_reset();
    send(1000, 32'd0, 255, 1'b0);
    send(1000, 32'd0, 255, 1'b0);
    send(1000, 32'd0, 255, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    gain_m = 512;
    expq.delete(); expc.delete();
    repeat (6) @(posedge CLK);
    #2;
    chk("t6_no_valid", outq.size(), 0);
    clear_q();
    send(1000, 32'd0, 255, 1'b0);
    drain("t6");
    if (got.size() == 1) chk("t6_restart", got[0], 984);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tremolo_mod.md
Name: tremolo_mod

Overview:
- Amplitude-modulation (tremolo) stage directly downstream of the sine LFO generator.
- Consumes the generator's 32-bit LFO word (valid range 0..512, midpoint 256) and a mono audio sample stream.
- Output samples are scaled by a depth-controlled, slew-limited gain.
- Sits between the audio input path and the effects output mux.

Parameters:
- SAMPLE_W, 16, signed audio sample width.
- SLEW_STEP, 8, maximum gain change per accepted sample (0 = slew limiting disabled; gain jumps directly to target).

Ports:
- CLK  in  1  system clock; the only clock in the block.
- RST  in  1  reset, synchronous, active-high.
- sample_in  in  SAMPLE_W  signed audio sample.
- in_valid  in  1  sample_in valid for this cycle; may be high every cycle.
- lfo  in  32  LFO word from the sine generator; sampled only when in_valid=1.
- depth  in  8  modulation depth; 0 = none, 255 = near-full.
- bypass  in  1  forces unity gain in the output path.
- sample_out  out  SAMPLE_W  signed modulated sample.
- out_valid  out  1  one-cycle strobe; sample_out valid.

Behaviour:
- Reset: sample_out=0, out_valid=0, all pipeline valids=0, gain_cur=512. Applies when RST is high on a CLK edge, including mid-stream: in-flight samples are discarded and no out_valid is produced for them.
- Pipeline has no stalls. in_valid high at edge N gives out_valid high at edge N+3; one output per input, in order. Back-to-back input at full rate is supported.
- S0 (accept on in_valid):
  - register sample_in, depth and bypass;
  - register lfo_c = min(lfo, 512), clamped over all 32 bits so any value above 512 becomes 512.
- S1 (target gain):
  - atten = (depth * (512 - lfo_c)) >> 8, unsigned, 17-bit product; atten range 0..510;
  - target = 512 - atten, 10-bit unsigned, range 2..512.
- S2 (slew and multiply):
  - executes only when S2 valid; gain_cur is held otherwise;
  - slew rule: if SLEW_STEP=0, gain_cur = target. Else if |target - gain_cur| <= SLEW_STEP, gain_cur = target. Else gain_cur moves SLEW_STEP toward target;
  - the multiply uses the updated gain_cur for the same sample;
  - g_eff = 512 if bypass else updated gain_cur;
  - product = sample * g_eff, signed, SAMPLE_W+11 bits;
  - when bypass=1, gain_cur still tracks target, so releasing bypass produces no jump in the internal state.
- S3 (output):
  - sample_out = product >>> 9 (arithmetic shift, floor toward minus infinity);
  - no saturation is needed because g_eff <= 512 gives |out| <= |in|; -32768 * 512 >>> 9 = -32768;
  - out_valid asserts for one cycle; sample_out holds its last value when out_valid=0.
- depth, lfo and bypass changes that arrive without in_valid have no effect.

Decomposition:
- Package audio_fx_pkg holds:
  - SAMPLE_W default;
  - GAIN_UNITY=512, GAIN_SHIFT=9, LFO_MAX=512;
  - typedef sample_t (signed SAMPLE_W) and gain_t (unsigned 10-bit).
- Sub-module tremolo_gain_slew: holds gain_cur, computes the S2 slew update, and exposes the updated gain combinationally. Inputs: CLK, RST, en, target.
- Remaining pipeline stays in tremolo_mod.

Test Plan:
- Reset, then depth=255, lfo=512, sample 1000 -> gain stays 512; out 1000 exactly 3 cycles after in_valid.
- Reset, depth=0, lfo=0, sample -1234 -> target 512; out -1234.
- Reset, SLEW_STEP=8, depth=255, lfo=0, 64 consecutive samples of 1000:
  - gain sequence 504, 496, ..., 8, 2;
  - 1st out 984, 63rd out 15 (gain 8), 64th out 3 (gain 2);
  - sample -1000 at gain 2 -> -4 (floor).
- lfo=0xFFFF_FFFF, depth=255, sample 1000 -> clamped to 512; out 1000.
- Continuous in_valid at full rate, random inputs -> outputs in order and match a reference model bit-exactly; bypass=1 mid-run -> outputs equal inputs while gain_cur keeps tracking (check after bypass release).
- RST asserted for one cycle with 3 samples in flight -> no out_valid for them; next sample uses gain_cur=512 start point.
